pipe_hazard_sequencer: RTL and testbench

- Central controller for the 5-stage pipeline registers (F/D, D/E, E/M, M/W).
- Generates the F/D register enable, the D/E and F/D clears, a freeze for the later stages, and the E-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses with a wait-state FSM and a watchdog.
- Placed beside the datapath; drives the existing en/clr register inputs directly.

---
 rtl/pipe_hazard_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard controller: stage enables/clears, E-stage forwarding and the data-memory wait FSM.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipe_hazard_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [1:0]       resultSrcE,
  input  logic             pcSrcE,
  input  logic [4:0]       rdM,
  input  logic             regWriteM,
  input  logic [4:0]       rdW,
  input  logic             regWriteW,
  input  logic             memReqM,
  input  logic             memAckM,
  output logic             enF,
  output logic             enD,
  output logic             clrD,
  output logic             clrE,
  output logic             holdM,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [WaitW-1:0] wait_inc;
  logic             freeze;
  logic             lw_stall;

  // M-stage match takes priority over W-stage as it holds the newer value.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      if (regWriteM && rdM != 5'd0 && rdM == rs1E) begin
        forwardAE = 2'b10;
      end else if (regWriteW && rdW != 5'd0 && rdW == rs1E) begin
        forwardAE = 2'b01;
      end
      if (regWriteM && rdM != 5'd0 && rdM == rs2E) begin
        forwardBE = 2'b10;
      end else if (regWriteW && rdW != 5'd0 && rdW == rs2E) begin
        forwardBE = 2'b01;
      end
    end
  end

  assign lw_stall = (resultSrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    freeze = 1'b1;
    case (state_q)
      StRun:     freeze = memReqM && !memAckM;
      StMemWait: freeze = !memAckM;
      StTimeout: freeze = 1'b1;
      default:   freeze = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StRun: begin
        if (memReqM && !memAckM) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (memAckM) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= TimeoutVal) begin
            state_d = StTimeout;
          end
        end
      end
      StTimeout: state_d = StTimeout;
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Branch flush beats load-use stall; a memory freeze overrides both so they re-resolve later.
  always_comb begin
    enF   = 1'b1;
    enD   = 1'b1;
    clrD  = 1'b0;
    clrE  = 1'b0;
    holdM = 1'b0;
    if (!rst) begin
      enF  = 1'b0;
      enD  = 1'b0;
      clrD = 1'b1;
      clrE = 1'b1;
    end else if (freeze) begin
      enF   = 1'b0;
      enD   = 1'b0;
      holdM = 1'b1;
    end else if (pcSrcE) begin
      clrD = 1'b1;
      clrE = 1'b1;
    end else if (lw_stall) begin
      enF  = 1'b0;
      enD  = 1'b0;
      clrE = 1'b1;
    end
  end

  assign memTimeout = (state_q == StTimeout);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!enF && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!freeze && pcSrcE && flush_q != '1) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stallCount = stall_q;
  assign flushCount = flush_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed plus randomized bench for pipe_hazard_sequencer against a behavioural reference model.
module tb_pipe_hazard_sequencer;

  localparam int MT = 4;
  localparam int CW = 16;

  logic          clk, rst;
  logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]    resultSrcE;
  logic          pcSrcE, regWriteM, regWriteW, memReqM, memAckM;
  logic          enF, enD, clrD, clrE, holdM, memTimeout;
  logic [1:0]    forwardAE, forwardBE;
  logic [CW-1:0] stallCount, flushCount;

  pipe_hazard_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultSrcE(resultSrcE), .pcSrcE(pcSrcE), .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW),
    .regWriteW(regWriteW), .memReqM(memReqM), .memAckM(memAckM), .enF(enF), .enD(enD),
    .clrD(clrD), .clrE(clrE), .holdM(holdM), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .memTimeout(memTimeout), .stallCount(stallCount), .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: number of consecutive frozen cycles, plus a dead flag after timeout.
  int m_wait = 0;
  bit m_dead = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  localparam int CntMax = (1 << CW) - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultSrcE = 0; pcSrcE = 0; regWriteM = 0; regWriteW = 0; memReqM = 0; memAckM = 0;
  endtask

  // Checks outputs for the current inputs, advances the model across the next edge.
  task automatic cycle(input string tag);
    logic       frz, lw;
    logic       e_enF, e_enD, e_clrD, e_clrE, e_hold, e_to;
    logic [1:0] e_fa, e_fb;
    int         e_sc, e_fc;
    #1;
    frz = 1'b0;
    if (!rst) begin
      m_wait = 0; m_dead = 0; m_stall = 0; m_flush = 0;
      e_enF = 0; e_enD = 0; e_clrD = 1; e_clrE = 1; e_hold = 0; e_fa = 0; e_fb = 0; e_to = 0;
    end else begin
      frz = m_dead || ((m_wait > 0 || memReqM) && !memAckM);
      lw = (resultSrcE == 2'b01) && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      e_fa = fwd(rs1E);
      e_fb = fwd(rs2E);
      e_to = m_dead;
      e_hold = frz;
      if (frz)         begin e_enF = 0; e_enD = 0; e_clrD = 0; e_clrE = 0; end
      else if (pcSrcE) begin e_enF = 1; e_enD = 1; e_clrD = 1; e_clrE = 1; end
      else if (lw)     begin e_enF = 0; e_enD = 0; e_clrD = 0; e_clrE = 1; end
      else             begin e_enF = 1; e_enD = 1; e_clrD = 0; e_clrE = 0; end
    end
`ifdef HAZARD_PERF_EN
    e_sc = m_stall; e_fc = m_flush;
`else
    e_sc = 0; e_fc = 0;
`endif
    chk({tag, ".enF"}, 32'(enF), 32'(e_enF));
    chk({tag, ".enD"}, 32'(enD), 32'(e_enD));
    chk({tag, ".clrD"}, 32'(clrD), 32'(e_clrD));
    chk({tag, ".clrE"}, 32'(clrE), 32'(e_clrE));
    chk({tag, ".holdM"}, 32'(holdM), 32'(e_hold));
    chk({tag, ".forwardAE"}, 32'(forwardAE), 32'(e_fa));
    chk({tag, ".forwardBE"}, 32'(forwardBE), 32'(e_fb));
    chk({tag, ".memTimeout"}, 32'(memTimeout), 32'(e_to));
    chk({tag, ".stallCount"}, 32'(stallCount), 32'(e_sc));
    chk({tag, ".flushCount"}, 32'(flushCount), 32'(e_fc));
    if (rst) begin
      if (!e_enF && m_stall < CntMax) m_stall++;
      if (!frz && pcSrcE && m_flush < CntMax) m_flush++;
      if (!m_dead) begin
        if (frz) begin
          m_wait++;
          if (m_wait >= MT) m_dead = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);

    // Reset held for 3 cycles with matching forwarding sources present.
    rs1E = 5; rs2E = 5; rdM = 5; regWriteM = 1; memReqM = 1;
    repeat (3) cycle("reset");
    clear_inputs();
    rst = 1'b1;
    cycle("post_reset");

    // Forwarding priority.
    rs1E = 5; rdM = 5; regWriteM = 1; rdW = 5; regWriteW = 1; rs2E = 5;
    cycle("fwd_m");
    rdM = 0;
    cycle("fwd_w");
    rs2E = 0; rdW = 0;
    cycle("fwd_none");
    clear_inputs();

    // Load-use stall, then branch overriding it.
    resultSrcE = 2'b01; rdE = 7; rs2D = 7;
    cycle("lw_stall");
    pcSrcE = 1;
    cycle("lw_branch");
    clear_inputs();
    cycle("idle1");

    // Three wait cycles then ack.
    memReqM = 1;
    repeat (3) cycle("mem_wait");
    memAckM = 1;
    cycle("mem_ack");
    clear_inputs();
    cycle("idle2");

    // Branch during a freeze is held until the ack cycle.
    memReqM = 1; pcSrcE = 1;
    repeat (2) cycle("frz_branch");
    memAckM = 1;
    cycle("frz_release");
    clear_inputs();
    cycle("idle3");

    // Watchdog timeout, absorbing until reset.
    memReqM = 1;
    repeat (7) cycle("timeout");
    memAckM = 1;
    cycle("timeout_ack_ignored");
    rst = 1'b0;
    cycle("timeout_reset");
    clear_inputs();
    rst = 1'b1;
    cycle("timeout_recover");

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3));
      rdW = 5'($urandom_range(0, 3));
      resultSrcE = 2'($urandom_range(0, 3));
      pcSrcE = ($urandom_range(0, 4) == 0);
      regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      memReqM = 1'($urandom);
      memAckM = ($urandom_range(0, 9) < 6);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
